decode_issue_stage: RTL

//  RV32I/M decode stage with a built-in ID/EX pipeline register and valid/ready flow control.

---
 rtl/decode_issue_stage.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_issue_stage.sv
// rtl/decode_issue_stage.sv - RV32I/M decode with ID/EX register, WB bypass, load-use stall and flush
module decode_issue_stage #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic            out_alu_src,
    output logic            out_mem_write,
    output logic            out_wb_load,
    output logic            out_wb_reg_file,
    output logic [2:0]      out_mem_load_type,
    output logic [1:0]      out_mem_store_type,
    output logic            out_illegal
);

    localparam int AW = $clog2(NUM_REGS);

    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic            alu_src;
        logic            mem_write;
        logic            wb_load;
        logic            wb_reg_file;
        logic [2:0]      load_type;
        logic [1:0]      store_type;
        logic            illegal;
    } bundle_t;

    logic [XLEN-1:0] rf_q [NUM_REGS];

    bundle_t         dec;
    bundle_t         bundle_d, bundle_q;
    logic            valid_d, valid_q;
    logic [XLEN-1:0] op1_d, op1_q, op2_d, op2_q;

    logic [31:0]     imm32;
    logic            known_op;
    logic            idx_bad;
    logic            uses_rs2;
    logic            stall;
    logic            capture;
    logic            hold;
    logic            wb_ok;
    logic            hit1, hit2;
    logic [XLEN-1:0] rs1_rf, rs2_rf, rs1_port, rs2_port, rs1_cap, rs2_cap;

    // Writes to x0 and to indices beyond the implemented file are dropped.
    assign wb_ok   = wb_en && (wb_addr != 5'd0) && (32'(wb_addr) < NUM_REGS);
    assign idx_bad = (32'(in_instr[19:15]) >= NUM_REGS) || (32'(in_instr[24:20]) >= NUM_REGS)
                  || (32'(in_instr[11:7]) >= NUM_REGS);

    // Immediate extraction: S, B, J and U formats, I format for everything else.
    always_comb begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        case (in_instr[6:0])
            OP_STORE:        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OP_BRANCH:       imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                      in_instr[30:25], in_instr[11:8], 1'b0};
            OP_JAL:          imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                      in_instr[20], in_instr[30:21], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {in_instr[31:12], 12'h000};
            default:         imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        endcase
    end

    // Control decode; an unknown opcode leaves every write/memory flag cleared.
    always_comb begin
        dec             = '0;
        known_op        = 1'b1;
        dec.pc          = in_pc;
        dec.imm         = XLEN'($signed(imm32));
        dec.rs1         = in_instr[19:15];
        dec.rs2         = in_instr[24:20];
        dec.rd          = in_instr[11:7];
        dec.opcode      = in_instr[6:0];
        dec.func3       = in_instr[14:12];
        dec.func7       = in_instr[31:25];
        case (in_instr[6:0])
            OP_REG:    dec.wb_reg_file = 1'b1;
            OP_IMM:    begin dec.alu_src = 1'b1; dec.wb_reg_file = 1'b1; end
            OP_LOAD:   begin
                dec.alu_src     = 1'b1;
                dec.wb_load     = 1'b1;
                dec.wb_reg_file = 1'b1;
                dec.load_type   = in_instr[14:12];
            end
            OP_STORE:  begin
                dec.alu_src    = 1'b1;
                dec.mem_write  = 1'b1;
                dec.store_type = in_instr[13:12];
            end
            OP_BRANCH: dec.alu_src = 1'b0;
            OP_JAL:    dec.wb_reg_file = 1'b1;
            OP_JALR, OP_LUI, OP_AUIPC: begin dec.alu_src = 1'b1; dec.wb_reg_file = 1'b1; end
            OP_FENCE, OP_SYSTEM: known_op = 1'b1;
            default:   known_op = 1'b0;
        endcase
        dec.illegal = !known_op || idx_bad;
    end

    // Register-file read ports; out-of-range indices read as zero.
    always_comb begin
        rs1_rf = '0;
        rs2_rf = '0;
        if (in_instr[19:15] != 5'd0 && 32'(in_instr[19:15]) < NUM_REGS)
            rs1_rf = rf_q[in_instr[15+AW-1:15]];
        if (in_instr[24:20] != 5'd0 && 32'(in_instr[24:20]) < NUM_REGS)
            rs2_rf = rf_q[in_instr[20+AW-1:20]];
    end

    // The read port optionally sees the write in flight; the pipeline-register load
    // always forwards it so a same-cycle writer is never missed.
    assign hit1     = wb_ok && (wb_addr == in_instr[19:15]);
    assign hit2     = wb_ok && (wb_addr == in_instr[24:20]);
    assign rs1_port = (WB_BYPASS != 0 && hit1) ? wb_data : rs1_rf;
    assign rs2_port = (WB_BYPASS != 0 && hit2) ? wb_data : rs2_rf;
    assign rs1_cap  = hit1 ? wb_data : rs1_port;
    assign rs2_cap  = hit2 ? wb_data : rs2_port;

    // Load-use hazard: rs1 always counts as a use, rs2 only for R/S/B formats.
    assign uses_rs2 = (in_instr[6:0] == OP_REG) || (in_instr[6:0] == OP_STORE)
                   || (in_instr[6:0] == OP_BRANCH);
    assign stall    = in_valid && ex_load_valid && (ex_load_rd != 5'd0)
                   && ((ex_load_rd == in_instr[19:15]) || (uses_rs2 && ex_load_rd == in_instr[24:20]));
    assign in_ready = !stall && (!valid_q || out_ready);
    assign capture  = in_valid && in_ready;
    assign hold     = valid_q && !out_ready;

    // Next state of the ID/EX register: flush beats capture beats hold.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d  = 1'b1;
            bundle_d = dec;
            op1_d    = rs1_cap;
            op2_d    = rs2_cap;
        end else if (hold) begin
            if (wb_ok && wb_addr == bundle_q.rs1) op1_d = wb_data;
            if (wb_ok && wb_addr == bundle_q.rs2) op2_d = wb_data;
        end else begin
            valid_d = 1'b0;
        end
    end

    // ID/EX register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
        end
    end

    // Register file; write-back commits even while flushing or stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (wb_ok) begin
            rf_q[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    assign out_valid          = valid_q;
    assign out_pc             = bundle_q.pc;
    assign out_op1            = op1_q;
    assign out_op2            = op2_q;
    assign out_rs1            = bundle_q.rs1;
    assign out_rs2            = bundle_q.rs2;
    assign out_rd             = bundle_q.rd;
    assign out_imm            = bundle_q.imm;
    assign out_opcode         = bundle_q.opcode;
    assign out_func3          = bundle_q.func3;
    assign out_func7          = bundle_q.func7;
    assign out_alu_src        = bundle_q.alu_src;
    assign out_mem_write      = bundle_q.mem_write;
    assign out_wb_load        = bundle_q.wb_load;
    assign out_wb_reg_file    = bundle_q.wb_reg_file;
    assign out_mem_load_type  = bundle_q.load_type;
    assign out_mem_store_type = bundle_q.store_type;
    assign out_illegal        = bundle_q.illegal;

endmodule
